// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID register: owns the PC, runs a req/ack
// handshake to instruction memory, and handles decode freeze and branch redirect.
module fetch_stage #(
    parameter int unsigned             WORD_LEN = 16,
    parameter logic [WORD_LEN-1:0]     PC_RESET = '0,
    parameter logic [WORD_LEN-1:0]     NOP_WORD = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                freeze,
    input  logic                br_taken,
    input  logic [WORD_LEN-1:0] br_offset,
    output logic                imem_req,
    output logic [WORD_LEN-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [WORD_LEN-1:0] imem_rdata,
    output logic [WORD_LEN-1:0] instruction,
    output logic [WORD_LEN-1:0] pc_out,
    output logic                valid_out
);

    typedef enum logic [1:0] {
        FETCH    = 2'd0,
        HOLD     = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WORD_LEN-1:0] pc_q, pc_d;
    logic [WORD_LEN-1:0] instr_q, instr_d;
    logic [WORD_LEN-1:0] pc_out_q, pc_out_d;
    logic                valid_q, valid_d;
    logic [WORD_LEN-1:0] skid_instr_q, skid_instr_d;
    logic [WORD_LEN-1:0] skid_pc_q, skid_pc_d;
    logic [WORD_LEN-1:0] redir_q, redir_d;
    logic [WORD_LEN-1:0] br_target;

    // The branch belongs to the instruction in IF/ID, so the target is relative to pc_out.
    assign br_target = pc_out_q + WORD_LEN'(1) + br_offset;

    // In REDIRECT the stale request is still outstanding, and pc_q still holds its address.
    assign imem_req  = !rst && (state_q != HOLD);
    assign imem_addr = pc_q;

    assign instruction = instr_q;
    assign pc_out      = pc_out_q;
    assign valid_out   = valid_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        pc_out_d     = pc_out_q;
        valid_d      = valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        redir_d      = redir_q;

        unique case (state_q)
            FETCH: begin
                if (freeze) begin
                    if (imem_ack) begin
                        skid_instr_d = imem_rdata;
                        skid_pc_d    = pc_q;
                        pc_d         = pc_q + WORD_LEN'(1);
                        state_d      = HOLD;
                    end
                end else if (br_taken) begin
                    instr_d = NOP_WORD;
                    valid_d = 1'b0;
                    if (imem_ack) begin
                        pc_d = br_target;
                    end else begin
                        redir_d = br_target;
                        state_d = REDIRECT;
                    end
                end else if (imem_ack) begin
                    instr_d  = imem_rdata;
                    pc_out_d = pc_q;
                    valid_d  = 1'b1;
                    pc_d     = pc_q + WORD_LEN'(1);
                end else begin
                    instr_d = NOP_WORD;
                    valid_d = 1'b0;
                end
            end
            HOLD: begin
                if (!freeze) begin
                    state_d = FETCH;
                    if (br_taken) begin
                        instr_d = NOP_WORD;
                        valid_d = 1'b0;
                        pc_d    = br_target;
                    end else begin
                        instr_d  = skid_instr_q;
                        pc_out_d = skid_pc_q;
                        valid_d  = 1'b1;
                    end
                end
            end
            REDIRECT: begin
                instr_d = NOP_WORD;
                valid_d = 1'b0;
                if (imem_ack) begin
                    pc_d    = redir_q;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FETCH;
            pc_q         <= PC_RESET;
            instr_q      <= NOP_WORD;
            pc_out_q     <= '0;
            valid_q      <= 1'b0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
            redir_q      <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            pc_out_q     <= pc_out_d;
            valid_q      <= valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            redir_q      <= redir_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random traffic, checked each
// cycle against a queue-based model of the fetch rules.
module tb_fetch_stage;
    localparam int W = 16;
    localparam logic [W-1:0] NOP = 16'h0000;

    logic         clk = 1'b0;
    logic         rst;
    logic         freeze;
    logic         br_taken;
    logic [W-1:0] br_offset;
    logic         imem_req;
    logic [W-1:0] imem_addr;
    logic         imem_ack;
    logic [W-1:0] imem_rdata;
    logic [W-1:0] instruction;
    logic [W-1:0] pc_out;
    logic         valid_out;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference state: next fetch PC, IF/ID contents, parked fetch, pending redirect.
    logic [W-1:0]   m_pc, m_instr, m_pcout, m_rtgt;
    logic           m_valid, m_rpend;
    logic [2*W-1:0] m_skid[$];

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk        (clk),
        .rst        (rst),
        .freeze     (freeze),
        .br_taken   (br_taken),
        .br_offset  (br_offset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instruction(instruction),
        .pc_out     (pc_out),
        .valid_out  (valid_out)
    );

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cyc %0d got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = 16'h0000;
        m_instr = NOP;
        m_pcout = 16'h0000;
        m_valid = 1'b0;
        m_rpend = 1'b0;
        m_rtgt  = 16'h0000;
        m_skid.delete();
    endtask

    task automatic step(input logic r, input logic f, input logic b,
                        input logic [W-1:0] off, input logic a);
        logic         exp_req;
        logic [W-1:0] tgt;
        logic [W-1:0] rd;
        rd         = m_pc + 16'h0100;
        rst        = r;
        freeze     = f;
        br_taken   = b;
        br_offset  = off;
        imem_ack   = a;
        imem_rdata = rd;
        #1;
        exp_req = !r && (m_skid.size() == 0);
        chk("req", {15'b0, imem_req}, {15'b0, exp_req});
        if (exp_req) chk("addr", imem_addr, m_pc);
        chk("instr", instruction, m_instr);
        chk("pc_out", pc_out, m_pcout);
        chk("valid", {15'b0, valid_out}, {15'b0, m_valid});
        $display("cyc %0d rst %b frz %b br %b ack %b req %b addr %h | instr %h pc %h v %b",
                 cyc, r, f, b, a, imem_req, imem_addr, instruction, pc_out, valid_out);

        tgt = m_pcout + 16'd1 + off;
        if (r) begin
            model_reset();
        end else if (m_rpend) begin
            m_instr = NOP;
            m_valid = 1'b0;
            if (a) begin
                m_pc    = m_rtgt;
                m_rpend = 1'b0;
            end
        end else if (m_skid.size() != 0) begin
            if (!f) begin
                if (b) begin
                    m_skid.delete();
                    m_instr = NOP;
                    m_valid = 1'b0;
                    m_pc    = tgt;
                end else begin
                    {m_instr, m_pcout} = m_skid.pop_front();
                    m_valid = 1'b1;
                end
            end
        end else if (f) begin
            if (a) begin
                m_skid.push_back({rd, m_pc});
                m_pc = m_pc + 16'd1;
            end
        end else if (b) begin
            m_instr = NOP;
            m_valid = 1'b0;
            if (a) begin
                m_pc = tgt;
            end else begin
                m_rtgt  = tgt;
                m_rpend = 1'b1;
            end
        end else if (a) begin
            m_instr = rd;
            m_pcout = m_pc;
            m_valid = 1'b1;
            m_pc    = m_pc + 16'd1;
        end else begin
            m_instr = NOP;
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        logic         r, f, b, a;
        logic [W-1:0] off;
        rst = 1'b1; freeze = 1'b0; br_taken = 1'b0; br_offset = '0;
        imem_ack = 1'b0; imem_rdata = '0;
        model_reset();
        @(posedge clk);
        #1;
        step(1, 0, 0, 16'd0, 0);

        // Zero-wait stream after reset
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 16'd0, 1);
            chk("seq_pc", pc_out, 16'(i));
            chk("seq_instr", instruction, 16'(i) + 16'h0100);
            chk("seq_valid", {15'b0, valid_out}, 16'd1);
        end

        // Two-cycle ack latency
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 16'd0, 0);
            step(0, 0, 0, 16'd0, 0);
            step(0, 0, 0, 16'd0, 1);
        end

        // Freeze with ack during the freeze: IF/ID holds pc_out 6, skid holds 7
        step(0, 1, 0, 16'd0, 1);
        chk("frz_pc0", pc_out, 16'd6);
        step(0, 1, 0, 16'd0, 1);
        chk("frz_pc1", pc_out, 16'd6);
        step(0, 1, 0, 16'd0, 0);
        chk("frz_pc2", pc_out, 16'd6);
        step(0, 0, 0, 16'd0, 0);
        chk("rel_pc", pc_out, 16'd7);
        chk("rel_addr", imem_addr, 16'd8);

        // Backward branch with zero-wait memory: pc_out 8 + 1 - 2 = 7
        step(0, 0, 0, 16'd0, 1);
        step(0, 0, 1, 16'hFFFE, 1);
        chk("br_valid", {15'b0, valid_out}, 16'd0);
        chk("br_addr", imem_addr, 16'd7);
        step(0, 0, 0, 16'd0, 1);
        chk("br_pc", pc_out, 16'd7);

        // Branch while fetch outstanding: 7 + 1 + 10 = 18
        step(0, 0, 1, 16'd10, 0);
        chk("rd_addr0", imem_addr, 16'd8);
        step(0, 0, 0, 16'd0, 0);
        chk("rd_addr1", imem_addr, 16'd8);
        step(0, 0, 0, 16'd0, 1);
        chk("rd_addr2", imem_addr, 16'd18);
        chk("rd_valid", {15'b0, valid_out}, 16'd0);

        // PC wrap: branch to 16'hFFFF then fetch sequentially
        step(0, 0, 0, 16'd0, 1);
        step(0, 0, 1, 16'hFFEC, 1);
        chk("wrap_addr0", imem_addr, 16'hFFFF);
        step(0, 0, 0, 16'd0, 1);
        chk("wrap_pc", pc_out, 16'hFFFF);
        chk("wrap_addr1", imem_addr, 16'h0000);

        // Reset while HOLD with a full skid
        step(0, 0, 0, 16'd0, 1);
        step(0, 1, 0, 16'd0, 1);
        chk("hold_req", {15'b0, imem_req}, 16'd0);
        step(1, 1, 0, 16'd0, 0);
        chk("rst_valid", {15'b0, valid_out}, 16'd0);
        chk("rst_instr", instruction, 16'h0000);
        chk("rst_addr", imem_addr, 16'h0000);
        step(0, 0, 0, 16'd0, 1);

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            r   = ($urandom_range(99) == 0);
            f   = ($urandom_range(3) == 0);
            b   = ($urandom_range(9) == 0);
            off = ($urandom_range(1) == 1) ? 16'($urandom) : 16'($urandom_range(8)) - 16'd4;
            a   = ($urandom_range(4) < 3);
            step(r, f, b, off, a);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
